// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, error codes, frame length, command bytes.
// Used by the host transmitter and the receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK_WAIT,
        RELEASE
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN = 11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a history flop for
// falling-edge detection. Idle level of both PS/2 lines is high.
module ps2_line_sync (
    input  logic clk,
    input  logic srst,
    input  logic line_i,
    output logic line_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign line_o = sync_q;
    assign fall_o = hist_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain line enables.
// Optional macro PS2_TX_ACK_CHECK_EN: check the device ack bit (no ack -> ERR_NOACK).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES    = 6000,
    parameter int START_HOLD_CYCLES = 50,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] tx_err_code,
    output logic       ps2_busy,
    input  logic       ps2_sclk_in,
    input  logic       ps2_sda_in,
    output logic       ps2_sclk_oe,
    output logic       ps2_sda_oe
);

    localparam int CNT_W = $clog2(max3(INHIBIT_CYCLES, START_HOLD_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT   = 4'(FRAME_LEN - 2);

    logic sclk_sync, sclk_fall;
    logic sda_sync, sda_fall;
    logic unused_sda_fall;

    ps2_line_sync u_sclk_sync (
        .clk    (sys_clk),
        .srst   (sys_rst),
        .line_i (ps2_sclk_in),
        .line_o (sclk_sync),
        .fall_o (sclk_fall)
    );

    ps2_line_sync u_sda_sync (
        .clk    (sys_clk),
        .srst   (sys_rst),
        .line_i (ps2_sda_in),
        .line_o (sda_sync),
        .fall_o (sda_fall)
    );

    assign unused_sda_fall = sda_fall;

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       frame_q, frame_d;
    logic             sclk_oe_q, sclk_oe_d;
    logic             sda_oe_q, sda_oe_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
`ifdef PS2_TX_ACK_CHECK_EN
    logic             ack_q, ack_d;
`endif

    logic timed_out;
    assign timed_out = (cnt_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        sclk_oe_d = sclk_oe_q;
        sda_oe_d  = sda_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = ERR_NONE;
`ifdef PS2_TX_ACK_CHECK_EN
        ack_d     = ack_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid && ready_q) begin
                    frame_d   = {1'b1, odd_parity(tx_data), tx_data};
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    sclk_oe_d = 1'b1;
                    sda_oe_d  = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d    = '0;
                    sda_oe_d = 1'b1;
                    state_d  = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START: begin
                // Releasing the clock line hands clocking to the device; the
                // timeout window starts here.
                if (cnt_q == START_LAST) begin
                    cnt_d     = '0;
                    sclk_oe_d = 1'b0;
                    state_d   = BITS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BITS: begin
                if (sclk_fall) begin
                    sda_oe_d  = ~frame_q[0];
                    frame_d   = frame_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    cnt_d     = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ACK_WAIT;
                    end
                end else if (timed_out) begin
                    sclk_oe_d = 1'b0;
                    sda_oe_d  = 1'b0;
                    err_d     = 1'b1;
                    code_d    = ERR_TIMEOUT;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK_WAIT: begin
                if (sclk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    ack_d = ~sda_sync;
`endif
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else if (timed_out) begin
                    sclk_oe_d = 1'b0;
                    sda_oe_d  = 1'b0;
                    err_d     = 1'b1;
                    code_d    = ERR_TIMEOUT;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (sclk_sync && sda_sync) begin
                    state_d = IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
                    if (ack_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_NOACK;
                    end
`else
                    done_d = 1'b1;
`endif
                end else if (sclk_fall) begin
                    cnt_d = '0;
                end else if (timed_out) begin
                    sclk_oe_d = 1'b0;
                    sda_oe_d  = 1'b0;
                    err_d     = 1'b1;
                    code_d    = ERR_TIMEOUT;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                sclk_oe_d = 1'b0;
                sda_oe_d  = 1'b0;
                state_d   = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            sclk_oe_q <= 1'b0;
            sda_oe_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            sclk_oe_q <= sclk_oe_d;
            sda_oe_q  <= sda_oe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_q     <= ack_d;
`endif
        end
    end

    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign tx_err_code = code_q;
    assign ps2_busy    = busy_q;
    assign ps2_sclk_oe = sclk_oe_q;
    assign ps2_sda_oe  = sda_oe_q;

endmodule
